marquee_scroller: RTL and testbench

MARQUEE_SCROLLER -- requirements
Module: marquee_scroller

---
 rtl/marquee_scroller.sv | 170 +++++++++++++++++
 tb/tb_marquee_scroller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/marquee_scroller.sv
// Multi-digit 7-segment marquee: static, scroll-once, scroll-loop and blink playback
// of a latched message, stepped by a programmable clock divider.
module marquee_scroller #(
   parameter int NUM_DIGITS = 4,
   parameter int MSG_LEN    = 8,
   parameter int STEP_DIV   = 27000,
   localparam int LW = $clog2(MSG_LEN + 1),
   localparam int SW = $clog2(MSG_LEN + NUM_DIGITS + 1),
   localparam int DW = $clog2(STEP_DIV)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [1:0]              mode,
   input  logic [MSG_LEN*7-1:0]    msg,
   input  logic [LW-1:0]           msg_len,
   output logic [NUM_DIGITS*7-1:0] display,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {
      IDLE,
      STATIC,
      SCROLL,
      BLINK
   } state_t;

   state_t                    state_q, state_d;
   logic [MSG_LEN*7-1:0]      msg_q, msg_d;
   logic [LW-1:0]             len_q, len_d;
   logic [1:0]                mode_q, mode_d;
   logic [SW-1:0]             step_q, step_d;
   logic [DW-1:0]             div_q, div_d;
   logic                      phase_q, phase_d;
   logic [NUM_DIGITS*7-1:0]   display_q, display_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic                      tick;
   logic                      last;
   logic [LW-1:0]             len_in;
   logic [SW-1:0]             last_step;

   // Field k shows char (s-(N-1-k)) when scrolling, char (N-1-k) when static.
   function automatic logic [NUM_DIGITS*7-1:0] frame(
      input logic [SW-1:0]        s,
      input logic                 scroll,
      input logic [MSG_LEN*7-1:0] m,
      input logic [LW-1:0]        len
   );
      int idx;
      frame = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         idx = scroll ? int'(s) - (NUM_DIGITS - 1 - k)
                      : NUM_DIGITS - 1 - k;
         for (int j = 0; j < MSG_LEN; j++) begin
            if (idx == j && j < int'(len))
               frame[7*k +: 7] = m[7*j +: 7];
         end
      end
   endfunction

   assign tick      = (div_q == DW'(STEP_DIV - 1));
   assign last_step = SW'(len_q) + SW'(NUM_DIGITS - 1);
   assign last      = (step_q == last_step);
   assign len_in    = (msg_len > LW'(MSG_LEN)) ? LW'(MSG_LEN) : msg_len;

   always_comb begin
      state_d   = state_q;
      msg_d     = msg_q;
      len_d     = len_q;
      mode_d    = mode_q;
      step_d    = step_q;
      div_d     = div_q;
      phase_d   = phase_q;
      display_d = display_q;
      done_d    = 1'b0;

      if (stop) begin
         state_d   = IDLE;
         step_d    = '0;
         div_d     = '0;
         phase_d   = 1'b0;
         display_d = '0;
      end else if (start) begin
         msg_d   = msg;
         len_d   = len_in;
         mode_d  = mode;
         step_d  = '0;
         div_d   = '0;
         phase_d = 1'b0;
         unique case (mode)
            2'd0:    state_d = STATIC;
            2'd3:    state_d = BLINK;
            default: state_d = SCROLL;
         endcase
         display_d = frame('0, (mode == 2'd1 || mode == 2'd2), msg, len_in);
      end else begin
         unique case (state_q)
            IDLE: begin
               display_d = '0;
            end
            STATIC: begin
               div_d = '0;
            end
            SCROLL: begin
               div_d = tick ? '0 : div_q + DW'(1);
               if (tick) begin
                  if (!last) begin
                     step_d    = step_q + SW'(1);
                     display_d = frame(step_q + SW'(1), 1'b1, msg_q, len_q);
                  end else if (mode_q == 2'd1) begin
                     state_d   = IDLE;
                     step_d    = '0;
                     div_d     = '0;
                     display_d = '0;
                     done_d    = 1'b1;
                  end else begin
                     step_d    = '0;
                     display_d = frame('0, 1'b1, msg_q, len_q);
                  end
               end
            end
            BLINK: begin
               div_d = tick ? '0 : div_q + DW'(1);
               if (tick) begin
                  phase_d   = ~phase_q;
                  // phase_q set means the new phase is even: content.
                  display_d = phase_q ? frame('0, 1'b0, msg_q, len_q) : '0;
               end
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         msg_q     <= '0;
         len_q     <= '0;
         mode_q    <= '0;
         step_q    <= '0;
         div_q     <= '0;
         phase_q   <= 1'b0;
         display_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         msg_q     <= msg_d;
         len_q     <= len_d;
         mode_q    <= mode_d;
         step_q    <= step_d;
         div_q     <= div_d;
         phase_q   <= phase_d;
         display_q <= display_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign display = display_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_marquee_scroller.sv
// Directed self-checking bench for marquee_scroller (4 digits, 8 chars, step every 4 clocks).
module tb_marquee_scroller;

   localparam int ND = 4;
   localparam int ML = 8;
   localparam int SD = 4;

   localparam logic [6:0] H = 7'd118;
   localparam logic [6:0] O = 7'd63;
   localparam logic [6:0] L = 7'd56;
   localparam logic [6:0] A = 7'd119;
   localparam logic [6:0] Z = 7'd0;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          stop;
   logic [1:0]    mode;
   logic [ML*7-1:0] msg;
   logic [3:0]    msg_len;
   logic [ND*7-1:0] display;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;
   int dcnt;
   int changed;
   logic [27:0] t [8];
   logic [27:0] held;

   always #5 clk = ~clk;

   marquee_scroller #(
      .NUM_DIGITS(ND),
      .MSG_LEN(ML),
      .STEP_DIV(SD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .stop(stop),
      .mode(mode),
      .msg(msg),
      .msg_len(msg_len),
      .display(display),
      .busy(busy),
      .done(done)
   );

   function automatic logic [27:0] fr(input logic [6:0] a3, a2, a1, a0);
      return {a3, a2, a1, a0};
   endfunction

   function automatic logic [55:0] mk(input logic [6:0] c0, c1, c2, c3,
                                      input logic [6:0] c4, c5, c6, c7);
      return {c7, c6, c5, c4, c3, c2, c1, c0};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      if (done) dcnt++;
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic go(input logic [55:0] m, input logic [3:0] len, input logic [1:0] md);
      msg = m; msg_len = len; mode = md; start = 1'b1;
      cyc();
      start = 1'b0;
      msg = 56'h5A_A5A5_5A5A_A5A5;
      msg_len = 4'd1;
      mode = 2'd0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; msg = '0; msg_len = '0;
      dcnt = 0;
      t[0] = fr(H, Z, Z, Z); t[1] = fr(O, H, Z, Z);
      t[2] = fr(L, O, H, Z); t[3] = fr(A, L, O, H);
      t[4] = fr(Z, A, L, O); t[5] = fr(Z, Z, A, L);
      t[6] = fr(Z, Z, Z, A); t[7] = fr(Z, Z, Z, Z);
      run(2);
      rst = 1'b0;
      chk("reset_display", 32'(display), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);

      // scroll once HOLA
      dcnt = 0;
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd4, 2'd1);
      chk("once_step0", 32'(display), 32'(t[0]));
      chk("once_busy", 32'(busy), 32'd1);
      for (int s = 1; s < 8; s++) begin
         run(3);
         if (s == 1) chk("once_spacing", 32'(display), 32'(t[0]));
         run(1);
         chk($sformatf("once_step%0d", s), 32'(display), 32'(t[s]));
      end
      chk("once_no_early_done", 32'(dcnt), 32'd0);
      run(4);
      chk("once_done", 32'(done), 32'd1);
      chk("once_busy_fall", 32'(busy), 32'd0);
      chk("once_blank", 32'(display), 32'd0);
      run(1);
      chk("once_done_pulse", 32'(done), 32'd0);

      // scroll loop HOLA, 3 passes
      dcnt = 0;
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd4, 2'd2);
      for (int p = 0; p < 3; p++) begin
         for (int s = 1; s <= 8; s++) begin
            run(4);
            chk($sformatf("loop_p%0d_s%0d", p, s % 8), 32'(display), 32'(t[s % 8]));
         end
      end
      chk("loop_no_done", 32'(dcnt), 32'd0);
      chk("loop_busy", 32'(busy), 32'd1);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("loop_stop_blank", 32'(display), 32'd0);
      chk("loop_stop_busy", 32'(busy), 32'd0);

      // static HO
      dcnt = 0;
      go(mk(H, O, Z, Z, Z, Z, Z, Z), 4'd2, 2'd0);
      held = fr(H, O, Z, Z);
      chk("static_first", 32'(display), 32'(held));
      changed = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (display !== held) changed++;
      end
      chk("static_held", 32'(changed), 32'd0);
      chk("static_busy", 32'(busy), 32'd1);
      stop = 1'b1; cyc(); stop = 1'b0;
      chk("static_stop_blank", 32'(display), 32'd0);
      chk("static_stop_busy", 32'(busy), 32'd0);
      chk("static_stop_done", 32'(dcnt), 32'd0);

      // blink HOLA
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd4, 2'd3);
      chk("blink_on0", 32'(display), 32'(fr(H, O, L, A)));
      run(3);
      chk("blink_on0_hold", 32'(display), 32'(fr(H, O, L, A)));
      run(1);
      chk("blink_off0", 32'(display), 32'd0);
      run(4);
      chk("blink_on1", 32'(display), 32'(fr(H, O, L, A)));
      run(4);
      chk("blink_off1", 32'(display), 32'd0);
      chk("blink_busy", 32'(busy), 32'd1);

      // start and stop together
      msg = mk(O, H, Z, Z, Z, Z, Z, Z); msg_len = 4'd2; mode = 2'd1;
      start = 1'b1; stop = 1'b1;
      cyc();
      start = 1'b0; stop = 1'b0;
      chk("startstop_blank", 32'(display), 32'd0);
      chk("startstop_busy", 32'(busy), 32'd0);

      // restart mid-scroll
      dcnt = 0;
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd4, 2'd1);
      run(8);
      chk("restart_pre", 32'(display), 32'(t[2]));
      go(mk(O, H, Z, Z, Z, Z, Z, Z), 4'd2, 2'd1);
      chk("restart_step0", 32'(display), 32'(fr(O, Z, Z, Z)));
      chk("restart_no_done", 32'(dcnt), 32'd0);
      run(4);
      chk("restart_step1", 32'(display), 32'(fr(H, O, Z, Z)));
      run(19);
      chk("restart_pre_done", 32'(dcnt), 32'd0);
      run(1);
      chk("restart_done", 32'(done), 32'd1);
      chk("restart_idle", 32'(busy), 32'd0);

      // msg_len 15 clamps to 8: last step 11
      dcnt = 0;
      go(mk(7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8), 4'd15, 2'd1);
      run(16);
      chk("clamp_step4", 32'(display), 32'(fr(7'd5, 7'd4, 7'd3, 7'd2)));
      run(16);
      chk("clamp_step8", 32'(display), 32'(fr(Z, 7'd8, 7'd7, 7'd6)));
      run(15);
      chk("clamp_pre_done", 32'(dcnt), 32'd0);
      run(1);
      chk("clamp_done", 32'(done), 32'd1);

      // msg_len 0
      dcnt = 0;
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd0, 2'd1);
      chk("len0_blank", 32'(display), 32'd0);
      chk("len0_busy", 32'(busy), 32'd1);
      run(15);
      chk("len0_pre_done", 32'(dcnt), 32'd0);
      run(1);
      chk("len0_done", 32'(done), 32'd1);

      // reset at step 2
      dcnt = 0;
      go(mk(H, O, L, A, Z, Z, Z, Z), 4'd4, 2'd1);
      run(8);
      chk("rst_pre", 32'(display), 32'(t[2]));
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("rst_display", 32'(display), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      run(40);
      chk("rst_no_done", 32'(dcnt), 32'd0);
      chk("rst_still_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
